trace_capture_unit: RTL

//  Synthesisable retirement-trace buffer for the pipelined MIPS core. Samples the

---
 rtl/trace_capture_unit_if.sv | 42 ++++
 rtl/trace_capture_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/trace_capture_unit_if.sv
// ---------------------------------------------------------------------------
// trace_capture_unit_if
//   Bundles the pipeline event tap and the record drain port of the trace
//   capture unit.
//   Event tap (core -> unit): ev_pc, ev_reg_we, ev_reg_addr, ev_reg_data,
//                             ev_mem_we, ev_mem_re, ev_mem_addr, ev_mem_data
//   Drain port:               rec_valid/rec_data (unit -> host),
//                             rec_ready (host -> unit)
//   Modports: master = core/host side that drives events and rec_ready,
//             slave  = the capture unit.
// ---------------------------------------------------------------------------
interface trace_capture_unit_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int STAMP_W = 16
);
  localparam int REC_W = STAMP_W + 8 + 2*ADDR_W + 2*DATA_W;

  logic [ADDR_W-1:0] ev_pc;
  logic              ev_reg_we;
  logic [4:0]        ev_reg_addr;
  logic [DATA_W-1:0] ev_reg_data;
  logic              ev_mem_we;
  logic              ev_mem_re;
  logic [ADDR_W-1:0] ev_mem_addr;
  logic [DATA_W-1:0] ev_mem_data;
  logic              rec_valid;
  logic              rec_ready;
  logic [REC_W-1:0]  rec_data;

  modport master (
    output ev_pc, ev_reg_we, ev_reg_addr, ev_reg_data,
           ev_mem_we, ev_mem_re, ev_mem_addr, ev_mem_data, rec_ready,
    input  rec_valid, rec_data
  );

  modport slave (
    input  ev_pc, ev_reg_we, ev_reg_addr, ev_reg_data,
           ev_mem_we, ev_mem_re, ev_mem_addr, ev_mem_data, rec_ready,
    output rec_valid, rec_data
  );
endinterface

// File: rtl/trace_capture_unit.sv
// ---------------------------------------------------------------------------
// trace_capture_unit
//   Retirement-trace buffer for the pipelined MIPS core. While in CAPTURE,
//   each cycle with a register write or data-memory access is stamped and
//   queued in a DEPTH-entry FIFO that a debug host drains over valid/ready.
//
//   Ports:
//     clk, rst      clock (rising edge), asynchronous active-high reset
//     arm           IDLE -> CAPTURE
//     stop          CAPTURE -> FROZEN
//     clear         flush FIFO, clear status and stamp, go IDLE
//     bus           event tap and record drain port (slave modport)
//     level         entries held, 0..DEPTH
//     overflow      sticky, at least one record dropped
//     drop_count    dropped records, saturating
//     state         0 IDLE, 1 CAPTURE, 2 FROZEN
//
//   Record, MSB first:
//     {stamp, flags{mem_re,mem_we,reg_we}, reg_addr, pc, reg_data,
//      mem_addr, mem_data}
//
//   Build option: define TRACE_R0_FILTER_EN to drop writes to $0 from the
//   reg_we flag (a cycle whose only event is a $0 write pushes nothing).
// ---------------------------------------------------------------------------
module trace_capture_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     clear,
  trace_capture_unit_if.slave      bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic [1:0]               state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = STAMP_W + 8 + 2*ADDR_W + 2*DATA_W;
  localparam logic [PTR_W:0] LVL_FULL = DEPTH[PTR_W:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } state_t;

  state_t cur_state, nxt_state;

  logic [STAMP_W-1:0] stamp;
  logic [STAMP_W-1:0] stamp_inc;
  logic               reg_flag;
  logic [2:0]         flags;
  logic [REC_W-1:0]   record;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [REC_W-1:0]   mem [DEPTH];
  logic               full, empty;
  logic               push_req, push, pop, drop;

  // ---------------- control FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  // NOTE: the default assignment first keeps this block purely combinational;
  // a path that left nxt_state unassigned would infer a latch.
  always_comb begin
    nxt_state = cur_state;
    if (clear) begin
      nxt_state = IDLE;
    end else begin
      unique case (cur_state)
        IDLE:    if (arm)  nxt_state = CAPTURE;
        CAPTURE: if (stop) nxt_state = FROZEN;
        FROZEN:  nxt_state = FROZEN;
        default: nxt_state = IDLE;
      endcase
    end
  end

  assign state = cur_state;

  // ---------------- event formation ----------------
`ifdef TRACE_R0_FILTER_EN
  assign reg_flag = bus.ev_reg_we & (bus.ev_reg_addr != 5'd0);
`else
  assign reg_flag = bus.ev_reg_we;
`endif

  assign flags = {bus.ev_mem_re, bus.ev_mem_we, reg_flag};

  // The stamp names the capture cycle counted from 1: the first CAPTURE
  // cycle after arm records stamp 1 while the register advances to 1.
  assign stamp_inc = stamp + 1'b1;
  assign record = {stamp_inc, flags, bus.ev_reg_addr, bus.ev_pc, bus.ev_reg_data,
                   bus.ev_mem_addr, bus.ev_mem_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               stamp <= '0;
    else if (clear)                        stamp <= '0;
    else if (cur_state == IDLE && arm)     stamp <= '0;
    else if (cur_state == CAPTURE)         stamp <= stamp_inc;
  end

  // ---------------- FIFO ----------------
  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);

  // Clear cycle neither pops nor pushes; a full FIFO still accepts a push
  // when the head leaves in the same cycle.
  assign pop      = !empty && bus.rec_ready && !clear;
  assign push_req = (cur_state == CAPTURE) && !clear && (flags != 3'b000);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by level and the output
  // is forced to zero while empty, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= record;
  end

  assign bus.rec_valid = !empty;
  assign bus.rec_data  = empty ? '0 : mem[rd_ptr];

  // ---------------- drop status ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + 1'b1;
    end
  end

endmodule
